// File: rtl/line_tracker.sv
// Line tracker: synchronises and debounces three IR line sensors, then runs a
// tracking FSM that produces the motor steering mode plus halt/lost flags.
module line_tracker #(
    parameter int unsigned DEB_CYCLES   = 100_000,
    parameter int unsigned LOST_TIMEOUT = 50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [2:0] sensor_i,
    output logic [2:0] mode_o,
    output logic       halt_o,
    output logic       lost_o
);

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned SENS_W = 3;

    localparam logic [2:0] MODE_STRAIGHT   = 3'b111;
    localparam logic [2:0] MODE_SOFT_LEFT  = 3'b100;
    localparam logic [2:0] MODE_HARD_LEFT  = 3'b110;
    localparam logic [2:0] MODE_SOFT_RIGHT = 3'b011;
    localparam logic [2:0] MODE_HARD_RIGHT = 3'b001;
    localparam logic [2:0] MODE_SLOW       = 3'b000;

    typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_SEARCH, ST_HALT} state_e;
    typedef enum logic [1:0] {DIR_CENTER, DIR_LEFT, DIR_RIGHT} dir_e;

    logic [SENS_W-1:0] sync1_q, sync2_q;
    logic [SENS_W-1:0] cand_q, cand_d;
    logic [SENS_W-1:0] stable_q, stable_d;
    logic [CNT_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0]  lost_cnt_q, lost_cnt_d;
    state_e            state_q, state_d;
    dir_e              last_dir_q, last_dir_d;
    logic [2:0]        mode_q, mode_d;
    logic              halt_q, halt_d;
    logic              lost_q, lost_d;

    logic [2:0]        map_mode;
    dir_e              map_dir;
    logic              line_seen;

    // Debounce: a pattern must stay unchanged for DEB_CYCLES cycles before it is accepted.
    always_comb begin
        cand_d    = cand_q;
        deb_cnt_d = deb_cnt_q;
        stable_d  = stable_q;
        if (sync2_q != cand_q) begin
            cand_d    = sync2_q;
            deb_cnt_d = '0;
        end else if (deb_cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            stable_d  = cand_q;
        end else begin
            deb_cnt_d = deb_cnt_q + CNT_W'(1);
        end
    end

    // Sensor pattern to steering mode; an empty pattern keeps the last direction.
    always_comb begin
        map_mode = MODE_SLOW;
        map_dir  = last_dir_q;
        case (stable_q)
            3'b010, 3'b111, 3'b101: begin map_mode = MODE_STRAIGHT;   map_dir = DIR_CENTER; end
            3'b110:                 begin map_mode = MODE_SOFT_LEFT;  map_dir = DIR_LEFT;   end
            3'b100:                 begin map_mode = MODE_HARD_LEFT;  map_dir = DIR_LEFT;   end
            3'b011:                 begin map_mode = MODE_SOFT_RIGHT; map_dir = DIR_RIGHT;  end
            3'b001:                 begin map_mode = MODE_HARD_RIGHT; map_dir = DIR_RIGHT;  end
            default: ;
        endcase
    end

    assign line_seen = (stable_q != '0);

    // Next state, then outputs decoded from the state being entered.
    always_comb begin
        state_d    = state_q;
        lost_cnt_d = lost_cnt_q;
        last_dir_d = last_dir_q;
        mode_d     = MODE_SLOW;
        halt_d     = 1'b1;
        lost_d     = 1'b0;

        case (state_q)
            ST_IDLE:   if (enable_i) state_d = ST_TRACK;
            ST_TRACK:  if (!line_seen) begin
                           state_d    = ST_SEARCH;
                           lost_cnt_d = '0;
                       end
            ST_SEARCH: if (line_seen) begin
                           state_d = ST_TRACK;
                       end else if (lost_cnt_q == CNT_W'(LOST_TIMEOUT - 1)) begin
                           state_d = ST_HALT;
                       end else begin
                           lost_cnt_d = lost_cnt_q + CNT_W'(1);
                       end
            ST_HALT:   if (line_seen) state_d = ST_TRACK;
            default:   state_d = ST_IDLE;
        endcase

        if (!enable_i) state_d = ST_IDLE;

        case (state_d)
            ST_TRACK: begin
                mode_d     = map_mode;
                halt_d     = 1'b0;
                last_dir_d = map_dir;
            end
            ST_SEARCH: begin
                halt_d = 1'b0;
                lost_d = 1'b1;
                case (last_dir_q)
                    DIR_LEFT:  mode_d = MODE_HARD_LEFT;
                    DIR_RIGHT: mode_d = MODE_HARD_RIGHT;
                    default:   mode_d = MODE_SLOW;
                endcase
            end
            ST_HALT: lost_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            cand_q     <= '0;
            stable_q   <= '0;
            deb_cnt_q  <= '0;
            lost_cnt_q <= '0;
            state_q    <= ST_IDLE;
            last_dir_q <= DIR_CENTER;
            mode_q     <= MODE_SLOW;
            halt_q     <= 1'b1;
            lost_q     <= 1'b0;
        end else begin
            sync1_q    <= sensor_i;
            sync2_q    <= sync1_q;
            cand_q     <= cand_d;
            stable_q   <= stable_d;
            deb_cnt_q  <= deb_cnt_d;
            lost_cnt_q <= lost_cnt_d;
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            mode_q     <= mode_d;
            halt_q     <= halt_d;
            lost_q     <= lost_d;
        end
    end

    assign mode_o = mode_q;
    assign halt_o = halt_q;
    assign lost_o = lost_q;

endmodule

// File: tb/tb_line_tracker.sv
// Bench for line_tracker with short debounce/timeout: expected outputs are queued
// as stimulus is applied and popped when the DUT is sampled.
module tb_line_tracker;

    logic       clk = 1'b0;
    logic       clk_en;
    logic       rst_ni;
    logic       enable;
    logic [2:0] sensor;
    logic [2:0] mode;
    logic       halt;
    logic       lost;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q[$];
    string      tag_q[$];

    line_tracker #(
        .DEB_CYCLES   (4),
        .LOST_TIMEOUT (20)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .enable_i (enable),
        .sensor_i (sensor),
        .mode_o   (mode),
        .halt_o   (halt),
        .lost_o   (lost)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] m, input logic h, input logic l);
        exp_q.push_back({m, h, l});
        tag_q.push_back(tag);
    endtask

    task automatic compare_out();
        logic [4:0] e;
        string      t;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty observed=%0h expected=none", {mode, halt, lost});
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_val({t, "/mode"}, 32'(mode), 32'(e[4:2]));
            check_val({t, "/halt"}, 32'(halt), 32'(e[1]));
            check_val({t, "/lost"}, 32'(lost), 32'(e[0]));
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        clk_en = 1'b1;
        rst_ni = 1'b0;
        enable = 1'b0;
        sensor = 3'b000;
        step(3);
        expect_out("reset", 3'b000, 1'b1, 1'b0);
        compare_out();

        rst_ni = 1'b1;
        step(2);

        // First lock: straight line appears exactly 8 edges after application
        enable = 1'b1;
        sensor = 3'b010;
        expect_out("pre_lock", 3'b000, 1'b0, 1'b1);
        expect_out("lock",     3'b111, 1'b0, 1'b0);
        step(7);
        compare_out();
        step(1);
        compare_out();

        // Three-cycle dropout must not disturb tracking
        sensor = 3'b000;
        for (int i = 0; i < 12; i++) expect_out("glitch", 3'b111, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (i == 2) sensor = 3'b010;
            compare_out();
        end

        sensor = 3'b110;
        expect_out("soft_left", 3'b100, 1'b0, 1'b0);
        step(9);
        compare_out();

        // Line lost after a left sighting: hard left search, then halt on timeout
        sensor = 3'b000;
        expect_out("loss_track",  3'b100, 1'b0, 1'b0);
        expect_out("loss_search", 3'b110, 1'b0, 1'b1);
        expect_out("search_last", 3'b110, 1'b0, 1'b1);
        expect_out("timeout",     3'b000, 1'b1, 1'b1);
        for (int i = 1; i <= 28; i++) begin
            step(1);
            if (i == 7 || i == 8 || i == 27 || i == 28) compare_out();
        end

        sensor = 3'b001;
        expect_out("halt_hold", 3'b000, 1'b1, 1'b1);
        expect_out("recover",   3'b001, 1'b0, 1'b0);
        step(7);
        compare_out();
        step(1);
        compare_out();

        sensor = 3'b000;
        expect_out("right_search", 3'b001, 1'b0, 1'b1);
        step(8);
        compare_out();
        step(3);

        enable = 1'b0;
        expect_out("disable", 3'b000, 1'b1, 1'b0);
        step(1);
        compare_out();

        // Re-enable with no line: last direction (right) survives the idle period
        enable = 1'b1;
        expect_out("reenter", 3'b001, 1'b0, 1'b1);
        step(2);
        compare_out();
        step(2);

        @(negedge clk);
        clk_en = 1'b0;
        #12;
        expect_out("clk_stopped", 3'b001, 1'b0, 1'b1);
        compare_out();
        rst_ni = 1'b0;
        #1;
        expect_out("async_reset", 3'b000, 1'b1, 1'b0);
        compare_out();

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_left observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
